// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV64I control FSM with memory handshakes, branches, trap/halt and retire counter
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32,
  parameter bit SPLICE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             alu_equal,
  input  logic             alu_less,
  input  logic             alu_lessu,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteState,
  output logic             PCSource,
  output logic             ALUSrcA,
  output logic             LoadAOut,
  output logic             RegWrite,
  output logic             LoadRegA,
  output logic             LoadRegB,
  output logic             DMemOp,
  output logic             LoadMDR,
  output logic             IRWrite,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       MemToReg,
  output logic [1:0]       LoadSplice,
  output logic [1:0]       StoreSplice,
  output logic [3:0]       ALUOp,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [4:0] {
    RST, FETCH, DECODE, MEM_ADDR, LD_REQ, WB_LOAD, SD_REQ, R_EXEC, IMM_EXEC, U_EXEC,
    ARITH_WB, BRANCH, JUMP_LINK, JUMP_JAL, JUMP_JALR, HALT, TRAP
  } state_t;
  state_t           r_state, w_next;
  logic [TW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_instret;
  logic             r_halted, r_trap, w_inst, w_tmo, w_bvalid, w_bcond, w_f7, w_unused;
  logic [1:0]       r_cause, w_cause, w_spl;
  logic [2:0]       w_f3;
  logic [6:0]       w_op;
  logic [3:0]       w_aluop;
  assign w_op = instruction[6:0];
  assign w_f3 = instruction[14:12];
  assign w_f7 = instruction[30];
  assign w_unused = ^{instruction[31], instruction[29:15], instruction[11:7]};
  assign w_tmo = r_cnt == TW'(MEM_TIMEOUT - 1);
  assign w_bvalid = w_f3[2:1] != 2'b01;
  assign w_bcond = (w_f3[2:1] == 2'b00 ? alu_equal : w_f3[2:1] == 2'b10 ? alu_less : alu_lessu) ^ w_f3[0];
  assign w_spl = SPLICE_EN ? w_f3[1:0] : 2'b11;
  assign w_aluop = w_f3 == 3'd0 ? (w_f7 && r_state == R_EXEC ? ALU_SUB : ALU_ADD) :
                   w_f3 == 3'd1 ? ALU_SLL : w_f3 == 3'd2 ? ALU_SLT : w_f3 == 3'd3 ? ALU_SLTU :
                   w_f3 == 3'd4 ? ALU_XOR : w_f3 == 3'd5 ? (w_f7 ? ALU_SRA : ALU_SRL) :
                   w_f3 == 3'd6 ? ALU_OR : ALU_AND;
  assign PCWriteState = PCWrite | (PCWriteCond & w_bcond);
  assign halted = r_halted;
  assign trap = r_trap;
  assign trap_cause = r_cause;
  assign instret = r_instret;
  // next-state and Moore/ack-qualified control flags
  always_comb begin
    w_next = r_state;
    w_cause = r_cause;
    w_inst = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    PCSource = 1'b0;
    ALUSrcA = 1'b0;
    LoadAOut = 1'b0;
    RegWrite = 1'b0;
    LoadRegA = 1'b0;
    LoadRegB = 1'b0;
    DMemOp = 1'b0;
    LoadMDR = 1'b0;
    IRWrite = 1'b0;
    ALUSrcB = 2'd0;
    MemToReg = 2'd0;
    LoadSplice = 2'd0;
    StoreSplice = 2'd0;
    ALUOp = ALU_ADD;
    case (r_state)
      RST: w_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = imem_ack;
        PCWrite = imem_ack;
        w_next = imem_ack ? DECODE : w_tmo ? TRAP : FETCH;
        w_cause = 2'b10;
      end
      DECODE: begin
        LoadRegA = 1'b1;
        LoadRegB = 1'b1;
        LoadAOut = 1'b1;
        ALUSrcB = 2'd2;
        w_next = (w_op == 7'b0000011 || w_op == 7'b0100011) ? MEM_ADDR :
                 w_op == 7'b0010011 ? IMM_EXEC : w_op == 7'b0110011 ? R_EXEC :
                 w_op == 7'b0110111 ? U_EXEC : w_op == 7'b1100011 ? BRANCH :
                 (w_op == 7'b1101111 || w_op == 7'b1100111) ? JUMP_LINK :
                 w_op == 7'b1110011 ? HALT : TRAP;
        w_cause = 2'b01;
        w_inst = w_op == 7'b1110011;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        LoadAOut = 1'b1;
        w_next = w_op[5] ? SD_REQ : LD_REQ;
      end
      LD_REQ: begin
        dmem_req = 1'b1;
        LoadMDR = dmem_ack;
        w_next = dmem_ack ? WB_LOAD : w_tmo ? TRAP : LD_REQ;
        w_cause = 2'b11;
      end
      WB_LOAD: begin
        RegWrite = 1'b1;
        MemToReg = 2'd1;
        LoadSplice = w_spl;
        w_next = FETCH;
        w_inst = 1'b1;
      end
      SD_REQ: begin
        dmem_req = 1'b1;
        DMemOp = 1'b1;
        StoreSplice = w_spl;
        w_next = dmem_ack ? FETCH : w_tmo ? TRAP : SD_REQ;
        w_cause = 2'b11;
        w_inst = dmem_ack;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        LoadAOut = 1'b1;
        ALUOp = w_aluop;
        w_next = ARITH_WB;
      end
      IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        LoadAOut = 1'b1;
        ALUOp = w_aluop;
        w_next = ARITH_WB;
      end
      U_EXEC: begin
        ALUSrcB = 2'd2;
        LoadAOut = 1'b1;
        w_next = ARITH_WB;
      end
      ARITH_WB: begin
        RegWrite = 1'b1;
        w_next = FETCH;
        w_inst = 1'b1;
      end
      BRANCH: begin
        PCWriteCond = w_bvalid;
        PCSource = 1'b1;
        w_next = w_bvalid ? FETCH : TRAP;
        w_cause = 2'b01;
        w_inst = w_bvalid;
      end
      JUMP_LINK: begin
        RegWrite = 1'b1;
        MemToReg = 2'd2;
        w_next = w_op[3] ? JUMP_JAL : JUMP_JALR;
      end
      JUMP_JAL: begin
        PCWrite = 1'b1;
        PCSource = 1'b1;
        w_next = FETCH;
        w_inst = 1'b1;
      end
      JUMP_JALR: begin
        PCWrite = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        w_next = FETCH;
        w_inst = 1'b1;
      end
      HALT, TRAP: w_next = r_state;
      default: w_next = RST;
    endcase
  end
  // state, wait counter, retire counter and registered status
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RST;
      r_cnt <= '0;
      r_instret <= '0;
      r_halted <= 1'b0;
      r_trap <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt <= w_next != r_state ? '0 : r_cnt + TW'(imem_req | dmem_req);
      r_instret <= r_instret + CNT_W'(w_inst);
      r_halted <= w_next == HALT;
      r_trap <= w_next == TRAP;
      r_cause <= w_next == TRAP ? w_cause : 2'b00;
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the RV64I datapath (`processing`). It sequences fetch, decode, execute, memory and write-back for each instruction, and drives every datapath control flag. Unlike the fixed-wait controller it replaces, it adds:
- ready/ack handshakes on instruction and data memory, with a bounded timeout;
- all six branch conditions;
- illegal-opcode trap and ECALL/EBREAK halt states;
- a retired-instruction counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request waits for ack before trapping (≥1)
- CNT_W, 32, width of retired-instruction counter
- SPLICE_EN, 1, when 0 LoadSplice/StoreSplice are forced to the full-doubleword codes (SPL_LD/SPL_SD)

Ports (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- instruction  in  32  current IR contents from datapath
- alu_equal / alu_less / alu_lessu  in  1 each  ALU compare flags (signed/unsigned less)
- imem_ack  in  1  instruction memory data valid this cycle
- dmem_ack  in  1  data memory read data valid / write accepted this cycle
- imem_req  out  1  instruction read request
- dmem_req  out  1  data memory request
- PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR, IRWrite  out  1 each  datapath flags, encodings per the operations package
- ALUSrcB, MemToReg, LoadSplice, StoreSplice  out  2 each  datapath selects
- ALUOp  out  4  ALU operation code
- halted  out  1  core stopped by ECALL/EBREAK
- trap  out  1  core stopped by fault
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout
- instret  out  CNT_W  retired-instruction count

## Operation
- Defaults every cycle: all flags 0, ALUOp=SUM, then the state asserts only what it needs.
- PCWriteState = PCWrite | (PCWriteCond & branch_cond).
- branch_cond by funct3: BEQ eq; BNE !eq; BLT less; BGE !less; BLTU lessu; BGEU !lessu; other funct3 → TRAP cause 01 in BRANCH.
- States and transitions:
  - RST: → FETCH.
  - FETCH: imem_req=1, ALUSrcA=PC, ALUSrcB=CONST4, PCSource=ALU_OUT. On imem_ack: IRWrite=1, PCWrite=1, → DECODE. Otherwise stay.
  - DECODE: LoadRegA, LoadRegB, LoadAOut=1, ALU computes PC+imm. Dispatch on opcode:
    - 0000011 / 0100011 → MEM_ADDR
    - 0010011 → IMM_EXEC
    - 0110011 → R_EXEC
    - 0110111 → U_EXEC
    - 1100011 → BRANCH
    - 1101111 / 1100111 → JUMP_LINK
    - 1110011 → HALT
    - else → TRAP cause 01
  - MEM_ADDR: A+imm into ALUOut → LD_REQ or SD_REQ.
  - LD_REQ: dmem_req=1, DMemOp=0. On dmem_ack: LoadMDR=1, → WB_LOAD.
  - WB_LOAD: RegWrite=1, MemToReg=MDR, LoadSplice from funct3 → FETCH.
  - SD_REQ: dmem_req=1, DMemOp=1, StoreSplice from funct3. On dmem_ack → FETCH.
  - R_EXEC / IMM_EXEC / U_EXEC: LoadAOut=1, ALUOp from funct3/funct7 (funct7[5] selects SUB/SRA) → ARITH_WB.
  - ARITH_WB: RegWrite=1, MemToReg=ALU_OUT → FETCH.
  - BRANCH: PCWriteCond=1, PCSource=ALU_REG → FETCH.
  - JUMP_LINK: RegWrite=1, MemToReg=PC_4 → JUMP_JAL or JUMP_JALR.
  - JUMP_JAL / JUMP_JALR: PCWrite=1 → FETCH.
  - HALT, TRAP: absorbing until reset; all flags 0; no requests.
- Request holds: imem_req/dmem_req stay high continuously until the cycle ack is seen.
- Wait counter: counts request cycles without ack. When it reaches MEM_TIMEOUT → TRAP with cause 10 or 11, requests drop.
- Counter reset: zeroed on every state change.
- instret: +1 in the final cycle of each instruction (exit to FETCH from WB_LOAD, SD_REQ ack, ARITH_WB, BRANCH, JUMP_JAL/JALR), and on entry to HALT. Wraps modulo 2^CNT_W. Never increments on TRAP.

## Timing
- Reset values: state=RST, instret=0, halted=0, trap=0, trap_cause=00, counter=0, all flags/requests 0.
- Reset low in any state, including mid-request: next edge → RST, requests drop the same cycle the state register updates.
- Latency with ack in the request cycle:
  - R/I/U: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL/JALR: 4 cycles
- Each wait cycle adds 1 cycle.
- Ack in the same cycle the counter reaches MEM_TIMEOUT: ack wins, no trap.
- Ack while no request is outstanding: ignored.
- halted/trap are registered: asserted the cycle after entering the state.
- Flags are Moore outputs of state plus IR fields. Exceptions: ack-qualified IRWrite/PCWrite/LoadMDR, and PCWriteState (branch flags).

## Test plan
- add x3,x1,x2 (0x002081B3) with imem_ack immediate → states FETCH,DECODE,R_EXEC,ARITH_WB; RegWrite=1 on cycle 4; instret 0→1.
- ld (0x0000B103) with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, LoadMDR pulse on ack cycle, LoadSplice=SPL_LD in WB_LOAD, total 8 cycles.
- bgeu (funct3=111) with alu_lessu=0 → PCWriteState=1 in BRANCH; repeat with alu_lessu=1 → PCWriteState=0.
- Opcode 0x7F → TRAP, trap=1, trap_cause=01, instret unchanged; reset low one edge → all outputs at reset values, FETCH next.
- imem_ack never asserted, MEM_TIMEOUT=4 → trap_cause=10 after 4 request cycles; ack arriving exactly at cycle 4 → DECODE, no trap.
- CNT_W=4, 16 addi retired → instret wraps to 0; ECALL (0x00000073) → HALT, halted=1, instret+1.
